// File: rtl/regfile_writeback.sv
// Write-side front end of the 64x16 register file.
// Results from the ALU (channel A) and load/store (channel B) enter a small
// in-order queue and retire up to two per cycle onto the two register-file
// write ports and the carry-write port. Three combinational lookups let
// decode bypass results that have not reached the register file yet.
module regfile_writeback #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_carry_en,
  input  logic              a_carry,

  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_carry_en,
  input  logic              b_carry,

  output logic              in_ready,
  input  logic              rf_hold,

  output logic [ADDR_W-1:0] reg_wr1,
  output logic [ADDR_W-1:0] reg_wr2,
  output logic [DATA_W-1:0] reg_wr1_data,
  output logic [DATA_W-1:0] reg_wr2_data,
  output logic              reg_wr1_enable,
  output logic              reg_wr2_enable,
  output logic              carrybit_wr,
  output logic              carrybit_wr_enable,

  input  logic [ADDR_W-1:0] fwd_rd1,
  input  logic [ADDR_W-1:0] fwd_rd2,
  input  logic [ADDR_W-1:0] fwd_rd3,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic              fwd_hit3,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2,
  output logic [DATA_W-1:0] fwd_data3,
  output logic              fwd_carry_hit,
  output logic              fwd_carry,

  output logic              idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Two free slots are needed so both channels can always be accepted.
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);
  localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);

  // Queue storage, one field per array: {reg, data, carry_en, carry}
  logic [ADDR_W-1:0] q_reg  [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic              q_cen  [DEPTH];
  logic              q_car  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              a_acc;
  logic              b_acc;
  logic [PTR_W-1:0]  b_ptr;
  logic [PTR_W-1:0]  rd_ptr_p1;
  logic [CNT_W-1:0]  n_push;
  logic [CNT_W-1:0]  n_pop;

  // Queue positions in age order (0 = oldest) and whether each holds an entry
  logic [PTR_W-1:0]  scan_idx  [DEPTH];
  logic              scan_live [DEPTH];

  logic [ADDR_W-1:0] look_rd   [3];
  logic              look_hit  [3];
  logic [DATA_W-1:0] look_data [3];

  // Readiness depends only on the registered count; a pop this cycle gives no credit.
  assign in_ready  = (count <= READY_MAX);
  assign a_acc     = a_valid && in_ready;
  assign b_acc     = b_valid && in_ready;
  // A is older than B when both arrive, so B takes the slot after A.
  assign b_ptr     = a_acc ? (wr_ptr + PTR_W'(1)) : wr_ptr;
  assign rd_ptr_p1 = rd_ptr + PTR_W'(1);

  // Push/pop counts for this cycle; pops are min(count, 2) unless held.
  always_comb begin
    n_push = CNT_W'(a_acc) + CNT_W'(b_acc);
    n_pop  = '0;
    if (!rf_hold) begin
      if (count >= TWO) n_pop = TWO;
      else              n_pop = count;
    end
  end

  // Queue entry capture for accepted channels.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_reg[i]  <= '0;
        q_data[i] <= '0;
        q_cen[i]  <= 1'b0;
        q_car[i]  <= 1'b0;
      end
    end else begin
      if (a_acc) begin
        q_reg[wr_ptr]  <= a_reg;
        q_data[wr_ptr] <= a_data;
        q_cen[wr_ptr]  <= a_carry_en;
        q_car[wr_ptr]  <= a_carry;
      end
      if (b_acc) begin
        q_reg[b_ptr]  <= b_reg;
        q_data[b_ptr] <= b_data;
        q_cen[b_ptr]  <= b_carry_en;
        q_car[b_ptr]  <= b_carry;
      end
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      rd_ptr <= rd_ptr + PTR_W'(n_pop);
      count  <= count + n_push - n_pop;
    end
  end

  // Registered output stage: oldest popped entry on port 1, next on port 2.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_wr1            <= '0;
      reg_wr2            <= '0;
      reg_wr1_data       <= '0;
      reg_wr2_data       <= '0;
      reg_wr1_enable     <= 1'b0;
      reg_wr2_enable     <= 1'b0;
      carrybit_wr        <= 1'b0;
      carrybit_wr_enable <= 1'b0;
    end else begin
      reg_wr1_enable <= (n_pop != '0);
      reg_wr2_enable <= (n_pop == TWO);
      if (n_pop != '0) begin
        reg_wr1      <= q_reg[rd_ptr];
        reg_wr1_data <= q_data[rd_ptr];
      end
      if (n_pop == TWO) begin
        reg_wr2      <= q_reg[rd_ptr_p1];
        reg_wr2_data <= q_data[rd_ptr_p1];
      end
      // The younger carry-updating entry is the one the register file must keep.
      if ((n_pop == TWO) && q_cen[rd_ptr_p1]) begin
        carrybit_wr        <= q_car[rd_ptr_p1];
        carrybit_wr_enable <= 1'b1;
      end else if ((n_pop != '0) && q_cen[rd_ptr]) begin
        carrybit_wr        <= q_car[rd_ptr];
        carrybit_wr_enable <= 1'b1;
      end else begin
        carrybit_wr_enable <= 1'b0;
      end
    end
  end

  // Age-ordered view of the queue for the forwarding search.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx[i]  = rd_ptr + PTR_W'(i);
      scan_live[i] = (CNT_W'(i) < count);
    end
  end

  assign look_rd[0] = fwd_rd1;
  assign look_rd[1] = fwd_rd2;
  assign look_rd[2] = fwd_rd3;

  // Register forwarding: scan oldest to youngest so later matches override.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      look_hit[p]  = 1'b0;
      look_data[p] = '0;
      if (reg_wr1_enable && (reg_wr1 == look_rd[p])) begin
        look_hit[p]  = 1'b1;
        look_data[p] = reg_wr1_data;
      end
      if (reg_wr2_enable && (reg_wr2 == look_rd[p])) begin
        look_hit[p]  = 1'b1;
        look_data[p] = reg_wr2_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (scan_live[i] && (q_reg[scan_idx[i]] == look_rd[p])) begin
          look_hit[p]  = 1'b1;
          look_data[p] = q_data[scan_idx[i]];
        end
      end
    end
  end

  assign fwd_hit1  = look_hit[0];
  assign fwd_hit2  = look_hit[1];
  assign fwd_hit3  = look_hit[2];
  assign fwd_data1 = look_data[0];
  assign fwd_data2 = look_data[1];
  assign fwd_data3 = look_data[2];

  // Carry forwarding: the output stage already holds the younger of its pair.
  always_comb begin
    fwd_carry_hit = 1'b0;
    fwd_carry     = 1'b0;
    if (carrybit_wr_enable) begin
      fwd_carry_hit = 1'b1;
      fwd_carry     = carrybit_wr;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (scan_live[i] && q_cen[scan_idx[i]]) begin
        fwd_carry_hit = 1'b1;
        fwd_carry     = q_car[scan_idx[i]];
      end
    end
  end

  assign idle = (count == '0) && !reg_wr1_enable && !reg_wr2_enable && !carrybit_wr_enable;

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side front end of the pipeline's 64x16 register file; collects results from the ALU (channel A) and load/store (channel B) stages.
- Buffers results in a small in-order queue and retires up to two per cycle onto the register file's two write ports and carry-write port.
- Provides three forwarding lookups so decode can bypass results that have not yet reached the register file.

Parameters:
- DATA_W, 16, result/register data width
- ADDR_W, 6, register index width (64 registers)
- DEPTH, 4, queue entries; power of two, >= 2

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- a_valid  in  1  channel A result valid
- a_reg  in  ADDR_W  channel A destination register
- a_data  in  DATA_W  channel A result
- a_carry_en  in  1  channel A updates carry
- a_carry  in  1  channel A carry value
- b_valid, b_reg, b_data, b_carry_en, b_carry  in  1/ADDR_W/DATA_W/1/1  channel B, same meaning as A
- in_ready  out  1  both channels may present this cycle
- rf_hold  in  1  suppress retirement this cycle
- reg_wr1, reg_wr2  out  ADDR_W  write-port addresses
- reg_wr1_data, reg_wr2_data  out  DATA_W  write-port data
- reg_wr1_enable, reg_wr2_enable  out  1  write-port enables
- carrybit_wr, carrybit_wr_enable  out  1  carry write value/enable
- fwd_rd1..fwd_rd3  in  ADDR_W  lookup register indices
- fwd_hit1..fwd_hit3  out  1  lookup matched a pending write
- fwd_data1..fwd_data3  out  DATA_W  youngest pending value
- fwd_carry_hit, fwd_carry  out  1  pending carry update exists / its value
- idle  out  1  queue and output stage empty

Behaviour:
- Reset is asynchronous: queue empty, count=0, pointers=0, all write-port and carry outputs 0, enables 0, idle=1.
- Entry format: {reg, data, carry_en, carry}.
- in_ready = (DEPTH - count) >= 2, computed from registered count only; there is no same-cycle credit from a pop.
- Accept: a channel's data is captured when valid && in_ready at a rising edge. If A and B are both accepted, A is enqueued first (older).
- Presenting valid while in_ready=0 is a protocol violation; the block ignores the entry and keeps state unchanged.
- Retirement (the output stage is registered): each edge with rf_hold=0 pops min(count, 2) entries.
  - Oldest entry -> wr1, next -> wr2; enables reflect the number popped.
  - Enables are 1 for exactly one cycle per pop.
  - Address and data outputs hold their last values when enables are 0.
- With rf_hold=1: no pop, enables 0 next cycle, enqueue still allowed.
- Same register in both slots: both enables asserted; the register file applies wr2 last, so the younger value wins. No merging.
- Carry: if either popped entry has carry_en, carrybit_wr_enable=1 and carrybit_wr comes from the younger one that has carry_en.
- Latency: enqueue at edge N -> write enables high after edge N+1 -> register file updated at edge N+2. These are minimums, with rf_hold=0 and the entry at the head.
- Simultaneous push and pop: count_next = count + pushes - pops.
  - Pointers wrap modulo DEPTH.
  - count never exceeds DEPTH.
- Forwarding (combinational): search the output stage (enabled slots only) plus all valid queue entries.
  - Youngest match wins: queue youngest > queue oldest > wr2 > wr1.
  - fwd_hitN=0 and fwd_dataN=0 on a miss.
  - Carry forwarding follows the same search rule, applied to carry_en entries.
- idle = (count==0) && !reg_wr1_enable && !reg_wr2_enable && !carrybit_wr_enable.
- Reset asserted mid-operation discards all pending entries immediately; nothing is written to the register file.

Test Plan:
- After reset, A valid (reg 5, data 16'h1234) -> in_ready=1, and next edge wr1=5, data 16'h1234, enable=1 for one cycle; then idle=1.
- A (reg 3, 16'h00AA) and B (reg 3, 16'h00BB) in the same cycle -> one cycle later wr1=3/00AA and wr2=3/00BB both enabled; fwd_rd1=3 returns 00BB before and during the write.
- rf_hold=1 while 4 entries are pushed over 2 cycles -> count=4, in_ready=0; release hold -> 2 retirement cycles, wr1/wr2 in FIFO order, in_ready returns 1 after the first pop.
- A carry_en=1/carry=1 and B carry_en=1/carry=0, same cycle -> carrybit_wr_enable=1, carrybit_wr=0; fwd_carry_hit=1, fwd_carry=0 while pending.
- Continuous single pushes for 10 cycles, 16'h0000..16'h0009 -> pointers wrap with no loss; each value appears on wr1 exactly once, in order.
- Reset pulsed with 3 entries queued -> enables never assert, fwd_hit=0, idle=1 immediately.
